bcd_share_arbiter: RTL

Time-shares one sequential double-dabble binary-to-BCD engine among several watch display sources (seconds, minutes, hours, alarm). Requesters raise a level request with an 8-bit binary value; a round-robin arbiter grants one, latches its operand, runs eight shift/add-3 iterations and returns three BCD digits tagged with the requester index. It sits between the timekeeping counters and the display digit registers, replacing per-source combinational converters.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/dd_engine.sv | 60 ++++++
 rtl/bcd_share_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the time-shared binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CONV_CYCLES = 8;
  localparam int DIGIT_W     = 4;
  localparam int ID_W        = 2;
  localparam int CNT_W       = $clog2(CONV_CYCLES);

endpackage

// File: rtl/dd_engine.sv
// Sequential double-dabble engine: one add-3/shift iteration per step cycle.
// The next-iteration digits are exposed so the caller can capture the final
// result on the same edge as the last iteration.
module dd_engine
  import bcd_pkg::*;
#(
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step,
  input  logic [W-1:0]       operand,
  output logic               last,
  output logic [DIGIT_W-1:0] hundreds_nxt,
  output logic [DIGIT_W-1:0] tens_nxt,
  output logic [DIGIT_W-1:0] ones_nxt
);

  logic [W-1:0]       opnd;
  logic [DIGIT_W-1:0] hun_r, ten_r, one_r;
  logic [DIGIT_W-1:0] hun_c, ten_c, one_c;
  logic [CNT_W-1:0]   cnt;

  assign last = (cnt == CNT_W'(CONV_CYCLES - 1));

  // Add-3 correction per digit, then the one-bit left shift of the chain.
  always_comb begin
    hun_c = (hun_r >= DIGIT_W'(5)) ? hun_r + DIGIT_W'(3) : hun_r;
    ten_c = (ten_r >= DIGIT_W'(5)) ? ten_r + DIGIT_W'(3) : ten_r;
    one_c = (one_r >= DIGIT_W'(5)) ? one_r + DIGIT_W'(3) : one_r;
    hundreds_nxt = {hun_c[DIGIT_W-2:0], ten_c[DIGIT_W-1]};
    tens_nxt     = {ten_c[DIGIT_W-2:0], one_c[DIGIT_W-1]};
    ones_nxt     = {one_c[DIGIT_W-2:0], opnd[W-1]};
  end

  // Operand/digit scratch and iteration counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      opnd  <= '0;
      hun_r <= '0;
      ten_r <= '0;
      one_r <= '0;
      cnt   <= '0;
    end else if (start) begin
      opnd  <= operand;
      hun_r <= '0;
      ten_r <= '0;
      one_r <= '0;
      cnt   <= '0;
    end else if (step) begin
      opnd  <= {opnd[W-2:0], 1'b0};
      hun_r <= hundreds_nxt;
      ten_r <= tens_nxt;
      one_r <= ones_nxt;
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bcd_share_arbiter.sv
// Round-robin arbiter sharing one double-dabble engine among display sources.
module bcd_share_arbiter
  import bcd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   bin_flat,
  output logic [NREQ-1:0]     gnt,
  output logic                busy,
  output logic                done,
  output logic [ID_W-1:0]     done_id,
  output logic [DIGIT_W-1:0]  hundreds,
  output logic [DIGIT_W-1:0]  tens,
  output logic [DIGIT_W-1:0]  ones
);

  state_t             state;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    pick;
  logic               found;
  logic [W-1:0]       sel_operand;
  logic               start;
  logic               last;
  logic [DIGIT_W-1:0] hun_nxt, ten_nxt, one_nxt;

  // Round-robin search upward from the slot after the last grant.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      logic [ID_W-1:0] j;
      j = ID_W'((int'(last_grant) + k) % NREQ);
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = j;
      end
    end
  end

  // Operand mux for the chosen source.
  always_comb begin
    sel_operand = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (ID_W'(k) == pick) sel_operand = bin_flat[k*W +: W];
    end
  end

  assign start = (state == IDLE) && found;

  dd_engine #(.W(W)) u_engine (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .step         (state == SHIFT),
    .operand      (sel_operand),
    .last         (last),
    .hundreds_nxt (hun_nxt),
    .tens_nxt     (ten_nxt),
    .ones_nxt     (one_nxt)
  );

  // Control FSM with registered grant, status and result outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(NREQ - 1);
      gnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_id    <= '0;
      hundreds   <= '0;
      tens       <= '0;
      ones       <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt        <= NREQ'(1) << pick;
            busy       <= 1'b1;
            last_grant <= pick;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (last) begin
            hundreds <= hun_nxt;
            tens     <= ten_nxt;
            ones     <= one_nxt;
            done_id  <= last_grant;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
